// File: rtl/temporizador_pkg.sv
// ============================================================================
// Module  : temporizador_pkg
// Brief   : Shared types and helpers for the countdown timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package temporizador_pkg;

  localparam int TIEMPO_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONTANDO = 2'd1,
    ALARMA   = 2'd2,
    PAUSA    = 2'd3
  } estado_t;

  // Values up to 39 fit the 2-bit tens digit, so the full 5-bit range is safe.
  function automatic logic [5:0] bin2bcd(input logic [TIEMPO_W-1:0] bin);
    logic [1:0] tens;
    logic [3:0] units;
    if (bin >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(bin - 5'd30);
    end else if (bin >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(bin - 5'd20);
    end else if (bin >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(bin - 5'd10);
    end else begin
      tens  = 2'd0;
      units = 4'(bin);
    end
    return {tens, units};
  endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_segundo.sv
// ============================================================================
// Module  : divisor_segundo
// Brief   : Prescaler producing a one-cycle tick every CLK_HZ enabled cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_segundo #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] c_ultimo = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cuenta;

  assign o_tick = i_en && (r_cuenta == c_ultimo);

  // Clear has priority; when disabled the count is frozen, not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (i_clr || o_tick) begin
      r_cuenta <= '0;
    end else if (i_en) begin
      r_cuenta <= r_cuenta + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/temporizador_regresivo.sv
// ============================================================================
// Module  : temporizador_regresivo
// Brief   : Seconds countdown with BCD outputs, end pulse and timed alarm.
//           Optional pause on start pulse: define TEMPORIZADOR_PAUSA_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_regresivo
  import temporizador_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIEMPO_MAX = 20,
  parameter int ALARMA_SEG = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TIEMPO_W-1:0] i_tiempo_in,
  input  logic                i_habilitado,
  input  logic                i_inicio,
  output logic [TIEMPO_W-1:0] o_restante,
  output logic [1:0]          o_decenas,
  output logic [3:0]          o_unidades,
  output logic                o_contando,
  output logic                o_fin,
  output logic                o_alarma
);

  localparam int SEG_W = (ALARMA_SEG > 1) ? $clog2(ALARMA_SEG) : 1;
  localparam logic [SEG_W-1:0]    c_seg_ultimo = SEG_W'(ALARMA_SEG - 1);
  localparam logic [TIEMPO_W-1:0] c_tiempo_max = TIEMPO_W'(TIEMPO_MAX);

  estado_t             r_estado;
  estado_t             w_estado_sig;
  logic [TIEMPO_W-1:0] w_limitado;
  logic [TIEMPO_W-1:0] r_restante;
  logic [TIEMPO_W-1:0] w_restante_sig;
  logic [1:0]          r_decenas;
  logic [3:0]          r_unidades;
  logic [5:0]          w_bcd;
  logic                r_fin;
  logic                w_fin_sig;
  logic                r_alarma;
  logic                w_alarma_sig;
  logic [SEG_W-1:0]    r_seg;
  logic                w_tick;
  logic                w_en_div;
  logic                w_clr;
  logic                w_ultimo_seg;
  logic                w_pausa_conmuta;

  assign w_limitado   = (i_tiempo_in > c_tiempo_max) ? c_tiempo_max : i_tiempo_in;
  assign w_en_div     = (r_estado == CONTANDO) || (r_estado == ALARMA);
  assign w_ultimo_seg = w_tick && (r_seg == c_seg_ultimo);

`ifdef TEMPORIZADOR_PAUSA_EN
  // Pausing and resuming keep the partial second instead of restarting it.
  assign w_pausa_conmuta = (r_estado == PAUSA) != (w_estado_sig == PAUSA);
`else
  assign w_pausa_conmuta = 1'b0;
`endif

  assign w_clr = !i_habilitado || ((w_estado_sig != r_estado) && !w_pausa_conmuta);

  divisor_segundo #(
    .CLK_HZ (CLK_HZ)
  ) u_divisor (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_en_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    if (!i_habilitado) begin
      w_estado_sig = IDLE;
    end else begin
      case (r_estado)
        IDLE: begin
          if (i_inicio && (w_limitado != '0)) w_estado_sig = CONTANDO;
        end
        CONTANDO: begin
          if (w_tick && (r_restante <= TIEMPO_W'(1))) begin
            w_estado_sig = ALARMA;
          end
`ifdef TEMPORIZADOR_PAUSA_EN
          else if (i_inicio) begin
            w_estado_sig = PAUSA;
          end
`endif
        end
        ALARMA: begin
          if (i_inicio || w_ultimo_seg) w_estado_sig = IDLE;
        end
`ifdef TEMPORIZADOR_PAUSA_EN
        PAUSA: begin
          if (i_inicio) w_estado_sig = CONTANDO;
        end
`endif
        default: w_estado_sig = IDLE;
      endcase
    end
  end

  always_comb begin
    w_restante_sig = r_restante;
    w_fin_sig      = 1'b0;
    w_alarma_sig   = 1'b0;
    if (!i_habilitado) begin
      w_restante_sig = '0;
    end else begin
      case (r_estado)
        IDLE: w_restante_sig = w_limitado;
        CONTANDO: begin
          if (w_tick) begin
            if (r_restante != '0) w_restante_sig = r_restante - 1'b1;
            if (r_restante == TIEMPO_W'(1)) begin
              w_fin_sig    = 1'b1;
              w_alarma_sig = 1'b1;
            end
          end
        end
        ALARMA: begin
          w_restante_sig = '0;
          w_alarma_sig   = !(i_inicio || w_ultimo_seg);
        end
        default: w_restante_sig = r_restante;
      endcase
    end
  end

  assign w_bcd = bin2bcd(w_restante_sig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_restante <= '0;
      r_decenas  <= '0;
      r_unidades <= '0;
      r_fin      <= 1'b0;
      r_alarma   <= 1'b0;
      r_seg      <= '0;
    end else begin
      r_restante <= w_restante_sig;
      r_decenas  <= w_bcd[5:4];
      r_unidades <= w_bcd[3:0];
      r_fin      <= w_fin_sig;
      r_alarma   <= w_alarma_sig;
      if (w_estado_sig != ALARMA) begin
        r_seg <= '0;
      end else if ((r_estado == ALARMA) && w_tick) begin
        r_seg <= r_seg + 1'b1;
      end
    end
  end

  assign o_restante = r_restante;
  assign o_decenas  = r_decenas;
  assign o_unidades = r_unidades;
  assign o_fin      = r_fin;
  assign o_alarma   = r_alarma;
  assign o_contando = (r_estado == CONTANDO) || (r_estado == PAUSA);

endmodule

`default_nettype wire

// File: tb/tb_temporizador_regresivo.sv
// ============================================================================
// Module  : tb_temporizador_regresivo
// Brief   : Randomised scoreboard bench for temporizador_regresivo.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_temporizador_regresivo;

  localparam int CLK_HZ     = 10;
  localparam int TIEMPO_MAX = 20;
  localparam int ALARMA_SEG = 2;
`ifdef TEMPORIZADOR_PAUSA_EN
  localparam bit PAUSA_EN = 1'b1;
`else
  localparam bit PAUSA_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] tiempo_in = 5'd0;
  logic       habilitado = 1'b1;
  logic       inicio = 1'b0;
  logic [4:0] restante;
  logic [1:0] decenas;
  logic [3:0] unidades;
  logic       contando;
  logic       fin;
  logic       alarma;

  typedef struct packed {
    logic [4:0] rest;
    logic [1:0] dec;
    logic [3:0] uni;
    logic       cnt;
    logic       fin;
    logic       alm;
  } salida_t;

  salida_t esperado_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: elapsed running cycles and alarm cycles, plain arithmetic.
  int m_modo;   // 0 idle, 1 running, 2 alarm, 3 paused
  int m_carga;
  int m_corrido;
  int m_alarma_ciclos;
  int m_rest;
  bit m_fin;
  bit m_alarma;

  always #5 clk = ~clk;

  temporizador_regresivo #(
    .CLK_HZ     (CLK_HZ),
    .TIEMPO_MAX (TIEMPO_MAX),
    .ALARMA_SEG (ALARMA_SEG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tiempo_in  (tiempo_in),
    .i_habilitado (habilitado),
    .i_inicio     (inicio),
    .o_restante   (restante),
    .o_decenas    (decenas),
    .o_unidades   (unidades),
    .o_contando   (contando),
    .o_fin        (fin),
    .o_alarma     (alarma)
  );

  function automatic salida_t leer();
    salida_t s;
    s.rest = restante;
    s.dec  = decenas;
    s.uni  = unidades;
    s.cnt  = contando;
    s.fin  = fin;
    s.alm  = alarma;
    return s;
  endfunction

  function automatic string fmt(input salida_t s);
    return $sformatf("rest=%0d dec=%0d uni=%0d cnt=%0b fin=%0b alm=%0b",
                     s.rest, s.dec, s.uni, s.cnt, s.fin, s.alm);
  endfunction

  function automatic void model_reset();
    m_modo = 0; m_carga = 0; m_corrido = 0; m_alarma_ciclos = 0;
    m_rest = 0; m_fin = 1'b0; m_alarma = 1'b0;
  endfunction

  function automatic void model_step(input int tin, input bit hab, input bit ini);
    int lim;
    m_fin = 1'b0;
    if (!hab) begin
      m_modo = 0; m_rest = 0; m_alarma = 1'b0;
      return;
    end
    case (m_modo)
      0: begin
        lim    = (tin > TIEMPO_MAX) ? TIEMPO_MAX : tin;
        m_rest = lim;
        if (ini && lim > 0) begin
          m_modo = 1; m_carga = lim; m_corrido = 0;
        end
      end
      1: begin
        m_corrido++;
        m_rest = m_carga - m_corrido / CLK_HZ;
        if (m_corrido == m_carga * CLK_HZ) begin
          m_fin = 1'b1; m_alarma = 1'b1; m_modo = 2; m_alarma_ciclos = 0;
        end else if (ini && PAUSA_EN) begin
          m_modo = 3;
        end
      end
      2: begin
        m_alarma_ciclos++;
        if (ini || m_alarma_ciclos == ALARMA_SEG * CLK_HZ) begin
          m_modo = 0; m_alarma = 1'b0;
        end
      end
      default: if (ini) m_modo = 1;
    endcase
  endfunction

  function automatic salida_t modelo_salida();
    salida_t s;
    s.rest = 5'(m_rest);
    s.dec  = 2'(m_rest / 10);
    s.uni  = 4'(m_rest % 10);
    s.cnt  = (m_modo == 1) || (m_modo == 3);
    s.fin  = m_fin;
    s.alm  = m_alarma;
    return s;
  endfunction

  task automatic drive(input int tin, input bit hab, input bit ini);
    tiempo_in  = 5'(tin);
    habilitado = hab;
    inicio     = ini;
    model_step(tin, hab, ini);
    esperado_q.push_back(modelo_salida());
    @(posedge clk);
    #2;
    inicio = 1'b0;
  endtask

  task automatic chequear_cero(input string nombre);
    salida_t g;
    g = leer();
    checks++;
    if (g !== salida_t'(0)) begin
      errors++;
      $display("FAIL %s: got %s, expected all zero", nombre, fmt(g));
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (esperado_q.size() > 0) begin
        salida_t e;
        salida_t g;
        e = esperado_q.pop_front();
        g = leer();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL salida t=%0t: got %s, expected %s", $time, fmt(g), fmt(e));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chequear_cero("reset inicial");
    rst_n = 1'b1;

    drive(3, 1, 1);
    repeat (60) drive(3, 1, 0);

    drive(25, 1, 1);
    repeat (15) drive(25, 1, 0);
    drive(25, 0, 0);
    drive(25, 1, 0);

    drive(0, 1, 1);
    repeat (20) drive(0, 1, 0);

    drive(5, 1, 1);
    repeat (30) drive(5, 1, 0);
    drive(5, 0, 0);
    repeat (5) drive(5, 1, 0);

    drive(2, 1, 1);
    repeat (25) drive(2, 1, 0);
    drive(2, 1, 1);
    repeat (3) drive(2, 1, 0);

    drive(8, 1, 1);
    repeat (33) drive(8, 1, 0);
    drive(8, 1, 1);
    repeat (30) drive(8, 1, 0);
    drive(8, 1, 1);
    repeat (100) drive(8, 1, 0);

    repeat (3000) begin
      drive(int'($urandom_range(0, 31)),
            $urandom_range(0, 199) != 0,
            $urandom_range(0, 24) == 0);
    end

    drive(6, 1, 1);
    repeat (15) drive(6, 1, 0);
    rst_n = 1'b0;
    #1;
    chequear_cero("reset asincrono");
    @(posedge clk);
    #2;
    chequear_cero("reset sostenido");
    model_reset();
    rst_n = 1'b1;
    drive(4, 1, 1);
    repeat (70) drive(4, 1, 0);

    checks++;
    if (esperado_q.size() != 0) begin
      errors++;
      $display("FAIL cola: got %0d pending records, expected 0", esperado_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
